// File: rtl/pfb_ctrl.sv
// pfb_ctrl: run control, double-buffered coefficient bank and output-valid
// qualification for a polyphase filter bank.
//
// Optional feature: define PFB_CTRL_FRAME_CNT_EN to build the frame counter;
// without it frame_cnt is tied to zero.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | stopped; filt_valid held low, waiting for start
// ST_RUN   | upstream samples gated through to the filter
// ST_DRAIN | input closed, waiting OUT_LAT cycles for the filter to empty
//
// COEFF_DLY and OUT_LAT are expected to be at least 2 and 1 respectively.
module pfb_ctrl #(
    parameter int COEFF_WIDTH  = 16,
    parameter int NOF_TAPS     = 4,
    parameter int NOF_BRANCHES = 2,
    parameter int COEFF_DLY    = 2,
    parameter int OUT_LAT      = 5
) (
    input  logic                          clk_data,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          stop,
    input  logic                          data_in_valid,
    output logic                          filt_valid,
    output logic                          filt_rst,
    input  logic                          cfg_wr_en,
    input  logic [2:0]                    cfg_wr_addr,
    input  logic [COEFF_WIDTH-1:0]        cfg_wr_data,
    input  logic                          cfg_commit,
    output logic                          cfg_ready,
    output logic signed [COEFF_WIDTH-1:0] coeff_a,
    output logic signed [COEFF_WIDTH-1:0] coeff_b,
    output logic signed [COEFF_WIDTH-1:0] coeff_c,
    output logic signed [COEFF_WIDTH-1:0] coeff_d,
    output logic                          data_out_valid,
    output logic                          busy,
    output logic [15:0]                   frame_cnt
);

    localparam int NOF_WORDS = NOF_TAPS * NOF_BRANCHES;
    localparam int ADDR_W    = 3;
    localparam int BR_W      = (NOF_BRANCHES > 1) ? $clog2(NOF_BRANCHES) : 1;
    localparam int PRIME_W   = $clog2(NOF_WORDS + 1);
    localparam int DRAIN_W   = (OUT_LAT > 1) ? $clog2(OUT_LAT) : 1;

    localparam logic [BR_W-1:0]    LAST_BR    = BR_W'(NOF_BRANCHES - 1);
    localparam logic [PRIME_W-1:0] PRIME_FULL = PRIME_W'(NOF_WORDS);
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(OUT_LAT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } state_t;

    state_t                        state;
    logic [DRAIN_W-1:0]            drain_cnt;
    logic [BR_W-1:0]               branch;
    logic                          wrap;
    logic                          active;
    logic                          pending;
    logic                          swap_done;
    logic                          swap_now;
    logic                          wr_ok;
    logic signed [COEFF_WIDTH-1:0] bank [0:1][0:NOF_WORDS-1];
    logic [BR_W:0]                 tag_sr [0:COEFF_DLY-2];
    logic                          sel_bank;
    logic [BR_W-1:0]               sel_br;
    logic [PRIME_W-1:0]            prime_cnt;
    logic [OUT_LAT-1:0]            dv_sr;

    function automatic logic [ADDR_W-1:0] word_addr(input logic [BR_W-1:0] br, input int tap);
        return ADDR_W'(int'(br) * NOF_TAPS + tap);
    endfunction

    // Run gating and the filter clear pulse follow the state and this cycle's inputs.
    assign filt_valid = !rst && (state == ST_RUN) && data_in_valid;
    assign filt_rst   = !rst && (state == ST_IDLE) && start && !stop;
    assign busy       = (state != ST_IDLE);
    assign wrap       = filt_valid && (branch == LAST_BR);

    // Bank swap waits for a frame boundary while running so a frame never mixes banks.
    assign swap_now  = pending && !swap_done && ((state != ST_RUN) || wrap);
    assign wr_ok     = cfg_wr_en && !pending && ({29'd0, cfg_wr_addr} < 32'(NOF_WORDS));
    assign cfg_ready = !pending;

    // Each coefficient fetch uses the bank that was active when its sample was taken.
    assign {sel_bank, sel_br} = tag_sr[COEFF_DLY-2];

    // Run-control state machine; stop has priority over start.
    always_ff @(posedge clk_data) begin
        if (rst) begin
            state     <= ST_IDLE;
            drain_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start && !stop) state <= ST_RUN;
                end
                ST_RUN: begin
                    if (stop) begin
                        state     <= ST_DRAIN;
                        drain_cnt <= DRAIN_LOAD;
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt == '0) state <= ST_IDLE;
                    else drain_cnt <= drain_cnt - 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Branch counter mirrors the filter's internal branch selection.
    always_ff @(posedge clk_data) begin
        if (rst || filt_rst) begin
            branch <= '0;
        end else if (filt_valid) begin
            branch <= (branch == LAST_BR) ? '0 : branch + 1'b1;
        end
    end

    // Commit handshake: pending drops one cycle after the swap takes effect.
    always_ff @(posedge clk_data) begin
        if (rst) begin
            active    <= 1'b0;
            pending   <= 1'b0;
            swap_done <= 1'b0;
        end else begin
            swap_done <= swap_now;
            if (swap_now) active <= !active;
            if (swap_done) pending <= 1'b0;
            else if (cfg_commit) pending <= 1'b1;
        end
    end

    // Coefficient storage; only the shadow bank is writable.
    always_ff @(posedge clk_data) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int w = 0; w < NOF_WORDS; w++) begin
                    bank[b][w] <= '0;
                end
            end
        end else if (wr_ok) begin
            bank[!active][cfg_wr_addr] <= cfg_wr_data;
        end
    end

    // Bank/branch tag pipeline aligning coefficients with samples at the multipliers.
    always_ff @(posedge clk_data) begin
        if (rst) begin
            for (int i = 0; i < COEFF_DLY - 1; i++) begin
                tag_sr[i] <= '0;
            end
        end else begin
            tag_sr[0] <= {active, branch};
            for (int i = 1; i < COEFF_DLY - 1; i++) begin
                tag_sr[i] <= tag_sr[i-1];
            end
        end
    end

    // Registered coefficient fetch, the last stage of the coefficient delay.
    always_ff @(posedge clk_data) begin
        if (rst) begin
            coeff_a <= '0;
            coeff_b <= '0;
            coeff_c <= '0;
            coeff_d <= '0;
        end else begin
            coeff_a <= bank[sel_bank][word_addr(sel_br, 0)];
            coeff_b <= bank[sel_bank][word_addr(sel_br, 1)];
            coeff_c <= bank[sel_bank][word_addr(sel_br, 2)];
            coeff_d <= bank[sel_bank][word_addr(sel_br, 3)];
        end
    end

    // Samples since start, saturating once every tap of every branch holds real data.
    always_ff @(posedge clk_data) begin
        if (rst || filt_rst) begin
            prime_cnt <= '0;
        end else if (filt_valid && (prime_cnt != PRIME_FULL)) begin
            prime_cnt <= prime_cnt + 1'b1;
        end
    end

    // Output-valid delay line; samples taken before the filter was primed are masked.
    always_ff @(posedge clk_data) begin
        if (rst) begin
            dv_sr <= '0;
        end else begin
            dv_sr <= (dv_sr << 1) | OUT_LAT'(filt_valid && (prime_cnt == PRIME_FULL));
        end
    end

    assign data_out_valid = dv_sr[OUT_LAT-1];

`ifdef PFB_CTRL_FRAME_CNT_EN
    // Completed frames, saturating.
    always_ff @(posedge clk_data) begin
        if (rst) begin
            frame_cnt <= '0;
        end else if (wrap && (frame_cnt != 16'hFFFF)) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end
`else
    assign frame_cnt = 16'd0;
`endif

endmodule
